// File: rtl/key_schedule_seq.sv
// Iterative AES-128/192/256 key schedule: one 32-bit schedule word per clock into a word store,
// with a registered round-key read port indexed by round number.
module key_schedule_seq #(
    parameter int MAX_NK = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [0:32*MAX_NK-1]  key,
    input  logic [3:0]            rk_idx,
    output logic [0:127]          rk,
    output logic                  busy,
    output logic                  done,
    output logic                  rk_valid,
    output logic                  err
);
    localparam int NW = 4 * (MAX_NK + 7);
    localparam int AW = $clog2(NW);

    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, GEN, FIN} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Zero marks an unknown mode; the legality check also rejects sizes above MAX_NK.
    function automatic logic [3:0] nk_of(input logic [1:0] m);
        case (m)
            2'b00:   return 4'd4;
            2'b01:   return 4'd6;
            2'b10:   return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] m);
        case (m)
            2'b00:   return 4'd10;
            2'b01:   return 4'd12;
            2'b10:   return 4'd14;
            default: return 4'd0;
        endcase
    endfunction

    logic [31:0]   store [NW];

    state_e        state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [2:0]    wrap_q, wrap_d;
    logic [7:0]    rcon_q, rcon_d;
    logic [1:0]    cur_mode_q, cur_mode_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          rk_valid_q, rk_valid_d, err_q, err_d;
    logic [0:127]  rk_q, rk_d;

    logic          load_en, gen_we, mode_legal;
    logic [3:0]    nk_cur, nr_cur;
    logic [AW-1:0] last_idx, rd_base;
    logic [31:0]   prev_w, old_w, t_w, new_w;

    always_comb begin
        nk_cur     = nk_of(cur_mode_q);
        nr_cur     = nr_of(cur_mode_q);
        last_idx   = AW'({2'b00, nr_cur, 2'b00} + 8'd3);
        mode_legal = (nk_of(mode) != 4'd0) && (32'(nk_of(mode)) <= MAX_NK);

        prev_w = store[i_q - AW'(1)];
        old_w  = store[i_q - AW'(nk_cur)];
        if (wrap_q == 3'd0)
            t_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
        else if (nk_cur == 4'd8 && wrap_q == 3'd4)
            t_w = sub_word(prev_w);
        else
            t_w = prev_w;
        new_w = old_w ^ t_w;

        state_d    = state_q;
        i_d        = i_q;
        wrap_d     = wrap_q;
        rcon_d     = rcon_q;
        cur_mode_d = cur_mode_q;
        busy_d     = busy_q;
        rk_valid_d = rk_valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        load_en    = 1'b0;
        gen_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mode_legal) begin
                        cur_mode_d = mode;
                        i_d        = AW'(nk_of(mode));
                        wrap_d     = 3'd0;
                        rcon_d     = 8'h01;
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b1;
                        load_en    = 1'b1;
                        state_d    = GEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GEN: begin
                gen_we = 1'b1;
                i_d    = i_q + AW'(1);
                wrap_d = (wrap_q == 3'(nk_cur - 4'd1)) ? 3'd0 : wrap_q + 3'd1;
                if (wrap_q == 3'd0)
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                if (i_q == last_idx)
                    state_d = FIN;
            end
            FIN: begin
                busy_d     = 1'b0;
                done_d     = 1'b1;
                rk_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rd_base = AW'({rk_idx, 2'b00});
        if (rk_idx > nr_cur)
            rk_d = '0;
        else
            rk_d = {store[rd_base], store[rd_base + AW'(1)],
                    store[rd_base + AW'(2)], store[rd_base + AW'(3)]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            i_q        <= '0;
            wrap_q     <= '0;
            rcon_q     <= '0;
            cur_mode_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            err_q      <= 1'b0;
            rk_q       <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            wrap_q     <= wrap_d;
            rcon_q     <= rcon_d;
            cur_mode_q <= cur_mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rk_valid_q <= rk_valid_d;
            err_q      <= err_d;
            rk_q       <= rk_d;
        end
    end

    // Store has no reset; its contents only matter once rk_valid is set.
    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int k = 0; k < MAX_NK; k++)
                if (k < 32'(nk_of(mode)))
                    store[k] <= key[32*k +: 32];
        end
        if (gen_we)
            store[i_q] <= new_w;
    end

    assign rk       = rk_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rk_valid = rk_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq using published AES key-expansion vectors.
module tb_key_schedule_seq;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [0:255] key = '0;
    logic [3:0]   rk_idx = 4'd0;
    logic [0:127] rk;
    logic         busy, done, rk_valid, err;

    int n_checks = 0;
    int n_bad = 0;

    localparam logic [0:255] K128  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] K192  = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [0:255] K256A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:255] K256B = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    key_schedule_seq #(.MAX_NK(8)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .key(key),
        .rk_idx(rk_idx), .rk(rk), .busy(busy), .done(done),
        .rk_valid(rk_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [0:127] val);
        @(negedge clk);
        rk_idx = idx;
        @(negedge clk);
        val = rk;
    endtask

    // Starts an expansion and waits for done; optionally fires a second start mid-run.
    task automatic run_key(input logic [1:0] m, input logic [0:255] k, input int exp_lat,
                           input int inject_at, input string tag);
        int  cnt;
        bit  seen;
        bit  pre_ok;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        key   = k;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, 128'(busy), 128'd1);
        check({tag, " rk_valid_after_start"}, 128'(rk_valid), 128'd0);
        cnt    = 0;
        seen   = 0;
        pre_ok = 1;
        while (cnt < 100 && !seen) begin
            @(negedge clk);
            cnt++;
            if (done) seen = 1;
            else if (!busy || rk_valid) pre_ok = 0;
            start = (cnt == inject_at);
            if (cnt == inject_at) begin
                mode = 2'b10;
                key  = K256A;
            end
        end
        start = 1'b0;
        check({tag, " done_latency"}, 128'(cnt), 128'(exp_lat));
        check({tag, " busy_until_done"}, 128'(pre_ok), 128'd1);
        check({tag, " busy_valid_at_done"}, 128'({busy, rk_valid}), 128'b01);
    endtask

    initial begin
        logic [0:127] v;

        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_flags", 128'({busy, done, rk_valid, err}), 128'd0);
        check("reset_rk", rk, 128'h0);
        reset = 1'b0;

        // AES-128
        run_key(2'b00, K128, 41, 0, "aes128");
        @(negedge clk);
        check("aes128 done_pulse", 128'({done, rk_valid}), 128'b01);
        read_rk(4'd0, v);
        check("aes128 rk0", v, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_rk(4'd1, v);
        check("aes128 rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(4'd10, v);
        check("aes128 rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(4'd11, v);
        check("aes128 rk11", v, 128'h0);

        // Illegal mode leaves the stored schedule alone
        @(negedge clk);
        start = 1'b1;
        mode  = 2'b11;
        key   = K256B;
        @(negedge clk);
        start = 1'b0;
        check("illegal err", 128'({err, busy, rk_valid}), 128'b101);
        @(negedge clk);
        check("illegal err_pulse", 128'({err, busy}), 128'b00);
        read_rk(4'd10, v);
        check("illegal rk10_kept", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Start while busy is ignored
        run_key(2'b00, K128, 41, 10, "busy_start");
        check("busy_start err", 128'(err), 128'd0);
        read_rk(4'd10, v);
        check("busy_start rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192
        run_key(2'b01, K192, 47, 0, "aes192");
        read_rk(4'd0, v);
        check("aes192 rk0", v, 128'h8e73b0f7da0e6452c810f32b809079e5);
        read_rk(4'd12, v);
        check("aes192 w51", 128'(v[96:127]), 128'h01002202);
        read_rk(4'd13, v);
        check("aes192 rk13", v, 128'h0);

        // AES-256
        run_key(2'b10, K256A, 53, 0, "aes256a");
        read_rk(4'd1, v);
        check("aes256a rk1", v, 128'h101112131415161718191a1b1c1d1e1f);
        read_rk(4'd14, v);
        check("aes256a rk14", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        read_rk(4'd15, v);
        check("aes256a rk15", v, 128'h0);

        run_key(2'b10, K256B, 53, 0, "aes256b");
        read_rk(4'd14, v);
        check("aes256b w59", 128'(v[96:127]), 128'h706c631e);

        // Reset mid-GEN
        rk_idx = 4'd0;
        @(negedge clk);
        start = 1'b1;
        mode  = 2'b00;
        key   = K128;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("midreset busy_before", 128'(busy), 128'd1);
        check("midreset rk_before", rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        #2 reset = 1'b1;
        #1;
        check("midreset flags", 128'({busy, done, rk_valid, err}), 128'd0);
        check("midreset rk", rk, 128'h0);
        @(negedge clk);
        reset = 1'b0;
        run_key(2'b10, K256A, 53, 0, "after_reset");
        read_rk(4'd14, v);
        check("after_reset rk14", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Back-to-back: 256-bit start in the cycle after the 128-bit done
        run_key(2'b00, K128, 41, 0, "b2b_128");
        run_key(2'b10, K256A, 53, 0, "b2b_256");
        read_rk(4'd0, v);
        check("b2b rk0", v, 128'h000102030405060708090a0b0c0d0e0f);
        read_rk(4'd14, v);
        check("b2b rk14", v, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/key_schedule_seq.md
# key_schedule_seq

Iterative, run-time-configurable AES key schedule. It generates one 32-bit schedule word per clock for AES-128, AES-192 or AES-256, with the key size selected per operation. Round keys are held in an internal store and read out by round index. It sits between key load and the round datapath, and replaces the fully unrolled combinational expansion wherever area matters more than start-up latency.

## Interface
Parameters:
- `MAX_NK`, default 8: largest supported key length in words. Legal values are 4, 6 and 8. It sizes the key port and the word store (`4*(MAX_NK+7)` words).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request a new expansion; sampled only in IDLE.
- `mode`  in  2  key size, sampled with `start`: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal.
- `key`  in  `[0:32*MAX_NK-1]`  cipher key, MSB-first byte order, left-aligned. The first `32*Nk` bits are used; the rest are ignored.
- `rk_idx`  in  4  round-key index, 0..Nr.
- `rk`  out  `[0:127]`  round key `rk_idx`, which is schedule words `4*rk_idx .. 4*rk_idx+3`, concatenated low index first.
- `busy`  out  1  expansion in progress.
- `done`  out  1  one-cycle pulse when the schedule is complete.
- `rk_valid`  out  1  the store holds a complete schedule for `cur_mode`.
- `err`  out  1  one-cycle pulse: `start` was sampled in IDLE with an illegal mode.

## Operation
- Mode table:
  - 128: Nk = 4, Nr = 10, 44 words.
  - 192: Nk = 6, Nr = 12, 52 words.
  - 256: Nk = 8, Nr = 14, 60 words.
- Any mode with Nk > `MAX_NK` counts as illegal.
- States are IDLE, GEN and FIN.
- IDLE, `start` = 1, legal mode:
  - Latch `mode` into `cur_mode`.
  - Write key words `w[0..Nk-1]`.
  - Set counter i = Nk, rcon = 0x01.
  - Clear `rk_valid` and set `busy`.
  - Go to GEN.
- IDLE, `start` = 1, illegal mode: pulse `err`, stay in IDLE. The store and `rk_valid` are untouched.
- GEN: each cycle writes `w[i] = w[i-Nk] ^ t`, where t depends on i:
  - `i % Nk == 0`: t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}. Then rcon is updated to xtime(rcon): shift left 1, XOR 0x1B if bit 7 was set. This gives 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - Nk = 8 and `i % 8 == 4`: t = SubWord(w[i-1]).
  - Otherwise: t = w[i-1].
  - i increments each cycle. After writing word 4*(Nr+1)-1, go to FIN.
- FIN (one cycle): `done` = 1, `busy` = 0, `rk_valid` = 1, then go to IDLE.
- SubWord uses the team's forward S-box on all four bytes in parallel (4 lanes, combinational).
- `i % Nk` is held in a separate wrap counter, not computed with a divider.
- `start` while GEN or FIN is ignored: no error, and the running expansion is not disturbed.
- Read port:
  - `rk` is registered: `rk_idx` sampled at edge n appears after edge n.
  - `rk_idx` > Nr(`cur_mode`) returns 128'h0.
  - While `rk_valid` = 0, the `rk` content is don't-care.
  - The read port is usable in every state.
- Asynchronous `reset`, including mid-GEN:
  - State goes to IDLE.
  - `busy`, `done`, `err` and `rk_valid` go to 0.
  - `rk` goes to 0.
  - i, rcon and `cur_mode` go to 0.
  - Store contents are don't-care.

## Timing
- Reset values: every output is 0.
- `start` is sampled at edge 0. Words 0..Nk-1 are written at edge 0.
- Generated word Nk+k is written at edge k+1.
- `done`, `rk_valid` high / `busy` low in the cycle after edge G+1, where G = 40 / 46 / 52 for 128 / 192 / 256.
  - Latency from start edge to `done`: 41 / 47 / 53 cycles.
- `busy` is high from the cycle after edge 0 up to, but not including, the `done` cycle.
- A new `start` is accepted in the cycle after `done` (IDLE).
- `err` appears in the cycle after the illegal `start` is sampled.
- `rk` read latency is 1 cycle.

## Test plan
- **AES-128:** key 2b7e151628aed2a6abf7158809cf4f3c, mode 00.
  - `done` 41 cycles after start.
  - rk_idx 0 → key.
  - rk_idx 10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_idx 11 → 0.
- **AES-192:** key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, mode 01.
  - `done` at 47 cycles.
  - Last word w[51] = 01002202 (low 32 bits of rk 12).
- **AES-256:** key 000102…1f, mode 10.
  - `done` at 53 cycles.
  - rk_idx 14 → 24fc79ccbf0979e9371ac23c6d68de36.
  - Repeat with key 603deb10…0914dff4 and check w[59] = 706c631e.
- **Illegal mode / start while busy:**
  - mode 11 → `err` pulse, `busy` stays 0, previous schedule and `rk_valid` preserved.
  - `start` with a new key asserted mid-GEN → ignored, and the final rk 10 matches the original key.
- **Reset mid-GEN:**
  - Assert `reset` at cycle 20 of a 128-bit run → all outputs 0 immediately.
  - Then run an AES-256 start → correct rk 14 and `done` at 53 cycles.
- **Back-to-back:**
  - Start a 128-bit run, then a 256-bit run in the cycle after `done`.
  - `rk_valid` drops at the second start edge and rises with the second `done`.
  - Readout matches the 256-bit vectors.
